fetch_stage: RTL

//  Instruction-fetch front end of the 5-stage pipeline. Drives address_imem, captures q_imem into the F/D

---
 rtl/fetch_stage_if.sv | 44 ++++
 rtl/fetch_stage.sv | 104 ++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem address/data, hazard controls from downstream,
// and the F/D latch presented to decode.
// The perf_* counters exist only when FETCH_PERF_EN is defined.
interface fetch_stage_if;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic        stall_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] IR_D;
  logic [31:0] PC_D;
  logic        valid_D;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;

  // Fetch stage side.
  modport master (
    output address_imem, IR_D, PC_D, valid_D,
    output perf_fetched, perf_stalls, perf_flushes,
    input  q_imem, stall_f, redirect, redirect_pc
  );

  // Memory / pipeline side.
  modport slave (
    input  address_imem, IR_D, PC_D, valid_D,
    input  perf_fetched, perf_stalls, perf_flushes,
    output q_imem, stall_f, redirect, redirect_pc
  );
`else
  // Fetch stage side.
  modport master (
    output address_imem, IR_D, PC_D, valid_D,
    input  q_imem, stall_f, redirect, redirect_pc
  );

  // Memory / pipeline side.
  modport slave (
    input  address_imem, IR_D, PC_D, valid_D,
    output q_imem, stall_f, redirect, redirect_pc
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, imem address, and F/D latch.
// Per-edge priority is redirect > stall_f > normal fetch.
// Optional feature macro: FETCH_PERF_EN adds saturating perf counters
// (fetched / stalled / flushed cycles), cleared only by reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic          clock,
  input  logic          reset,   // asynchronous, active low
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    OP_FETCH,
    OP_STALL,
    OP_REDIRECT
  } op_e;

  op_e         op;
  logic [31:0] pc_q;
  logic [31:0] pc_inc;
  logic [31:0] ir_q;
  logic [31:0] pcd_q;
  logic        valid_q;

  // PC goes straight to imem; nothing else sits on this path.
  assign bus.address_imem = pc_q;
  // 32-bit modulo: 32'hFFFF_FFFF + 1 wraps to 0.
  assign pc_inc           = pc_q + PC_STEP;

  assign bus.IR_D    = ir_q;
  assign bus.PC_D    = pcd_q;
  assign bus.valid_D = valid_q;

  // Resolve this cycle's action by priority.
  always_comb begin
    // NOTE: default first so every path assigns op and no latch is inferred.
    op = OP_FETCH;
    if (bus.redirect)     op = OP_REDIRECT;
    else if (bus.stall_f) op = OP_STALL;
  end

  // PC and F/D latch; q_imem is only sampled on a normal fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSN;
      pcd_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      unique case (op)
        OP_REDIRECT: begin
          pc_q    <= bus.redirect_pc;
          ir_q    <= NOP_INSN;
          pcd_q   <= 32'h0;
          valid_q <= 1'b0;
        end
        OP_STALL: begin
          pc_q    <= pc_q;
          ir_q    <= ir_q;
          pcd_q   <= pcd_q;
          valid_q <= valid_q;
        end
        default: begin
          pc_q    <= pc_inc;
          ir_q    <= bus.q_imem;
          pcd_q   <= pc_inc;
          valid_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stalls_q;
  logic [31:0] perf_flushes_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stalls  = perf_stalls_q;
  assign bus.perf_flushes = perf_flushes_q;

  // Saturating event counters, one per action class.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= 32'h0;
      perf_stalls_q  <= 32'h0;
      perf_flushes_q <= 32'h0;
    end else begin
      if (op == OP_FETCH)    perf_fetched_q <= sat_inc(perf_fetched_q);
      if (op == OP_STALL)    perf_stalls_q  <= sat_inc(perf_stalls_q);
      if (op == OP_REDIRECT) perf_flushes_q <= sat_inc(perf_flushes_q);
    end
  end
`endif

endmodule
